exc_resolve: RTL and testbench

- MEM-stage exception resolver sitting directly upstream of the CP0 register file.
- Each cycle it collects per-instruction exception flags, checks data-address alignment, samples pending interrupts against CP0 Status/Cause, and picks one winner by fixed priority.
- It drives CP0's exception inputs (excepttype, instruction address, delay-slot flag, bad address) through a register.
- It generates the pipeline flush and redirect PC, then holds off new exceptions during a flush window.

---
 rtl/exc_pkg.sv | 36 +++
 rtl/exc_resolve_int_sync.sv | 27 ++
 rtl/exc_resolve.sv | 143 ++++++++++++++
 tb/tb_exc_resolve.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared exception codes, FSM state encoding and access-size encodings for the
// MEM-stage exception resolver and its CP0 consumer.
package exc_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } exc_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    case (size)
      SIZE_HALF: w_mis = addr_lo[0];
      SIZE_WORD: w_mis = |addr_lo;
      default:   w_mis = 1'b0;
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/exc_resolve_int_sync.sv
// SYNC_STAGES-deep flop chain bringing the asynchronous interrupt lines into
// the clk domain.
module int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_async,
  output logic [5:0] o_sync
);

  logic [5:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '{default: '0};
    end else begin
      r_stage[0] <= i_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/exc_resolve.sv
// MEM-stage exception resolver: picks one exception per instruction by fixed
// priority, registers it toward CP0 and drives the pipeline flush/redirect.
module exc_resolve
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        fetch_adel_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        mem_cancel_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  exc_state_t  r_state;
  logic [2:0]  r_cnt;

  logic [5:0]  w_sync_int;
  logic        w_int_take;
  logic        w_misaligned;
  logic        w_eval;
  logic [31:0] w_code;
  logic        w_bad_valid;
  logic [31:0] w_bad;
  logic        w_take;
  logic        w_unused;

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clk     (clk),
    .rst_n   (rst),
    .i_async (int_i),
    .o_sync  (w_sync_int)
  );

  assign w_int_take = (|({w_sync_int, cp0_cause_i[9:8]} & cp0_status_i[15:8]))
                      && cp0_status_i[0] && !cp0_status_i[1];
  assign w_misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  // Bubbles and stalled cycles never decide, so EPC always names a real instruction.
  assign w_eval = (r_state == IDLE) && inst_valid_i && !stall_i;

  always_comb begin
    w_code      = EXC_NONE;
    w_bad_valid = 1'b0;
    w_bad       = '0;
    if (w_int_take) begin
      w_code = EXC_INT;
    end else if (fetch_adel_i) begin
      w_code      = EXC_ADEL;
      w_bad_valid = 1'b1;
      w_bad       = pc_i;
    end else if (ri_i) begin
      w_code = EXC_RI;
    end else if (ov_i) begin
      w_code = EXC_OV;
    end else if (trap_i) begin
      w_code = EXC_TR;
    end else if (syscall_i) begin
      w_code = EXC_SYS;
    end else if (break_i) begin
      w_code = EXC_BP;
    end else if (load_i && w_misaligned) begin
      w_code      = EXC_ADEL;
      w_bad_valid = 1'b1;
      w_bad       = mem_addr_i;
    end else if (store_i && w_misaligned) begin
      w_code      = EXC_ADES;
      w_bad_valid = 1'b1;
      w_bad       = mem_addr_i;
    end else if (eret_i) begin
      w_code = EXC_ERET;
    end
  end

  assign w_take       = w_eval && (w_code != EXC_NONE);
  assign mem_cancel_o = (r_state == FLUSH) || w_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= IDLE;
      r_cnt               <= '0;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= '0;
      flush_o             <= 1'b0;
      new_pc_o            <= '0;
    end else begin
      excepttype_o <= EXC_NONE;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            excepttype_o        <= w_code;
            current_inst_addr_o <= pc_i;
            is_in_delayslot_o   <= is_in_delayslot_i;
            if (w_bad_valid) bad_addr_o <= w_bad;
            flush_o  <= 1'b1;
            r_cnt    <= 3'(FLUSH_CYCLES - 1);
            new_pc_o <= (w_code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            r_state  <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_cnt == '0) begin
            flush_o <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_unused = &{1'b0, cp0_cause_i[31:10], cp0_cause_i[7:0],
                      cp0_status_i[31:16], cp0_status_i[7:2]};

endmodule

// File: tb/tb_exc_resolve.sv
// Directed bench for exc_resolve: one instance with default parameters and
// one with a three-cycle flush window, both fed the same stimulus.
module tb_exc_resolve;

  logic        clk;
  logic        rst;
  logic [5:0]  int_i;
  logic        stall, valid, ds, adel, ri, ov, trap, sys, brk, eret, load, store;
  logic [1:0]  size;
  logic [31:0] pc, addr, status, cause, epc;

  logic [31:0] a_exc, a_cur, a_bad, a_npc;
  logic        a_ds, a_cancel, a_flush;
  logic [31:0] b_exc, b_cur, b_bad, b_npc;
  logic        b_ds, b_cancel, b_flush;

  int total = 0;
  int bad   = 0;

  exc_resolve u_a (
    .clk(clk), .rst(rst), .int_i(int_i), .stall_i(stall), .inst_valid_i(valid),
    .pc_i(pc), .is_in_delayslot_i(ds), .fetch_adel_i(adel), .ri_i(ri), .ov_i(ov),
    .trap_i(trap), .syscall_i(sys), .break_i(brk), .eret_i(eret), .load_i(load),
    .store_i(store), .mem_size_i(size), .mem_addr_i(addr), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .excepttype_o(a_exc),
    .current_inst_addr_o(a_cur), .is_in_delayslot_o(a_ds), .bad_addr_o(a_bad),
    .mem_cancel_o(a_cancel), .flush_o(a_flush), .new_pc_o(a_npc)
  );

  exc_resolve #(.FLUSH_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .int_i(int_i), .stall_i(stall), .inst_valid_i(valid),
    .pc_i(pc), .is_in_delayslot_i(ds), .fetch_adel_i(adel), .ri_i(ri), .ov_i(ov),
    .trap_i(trap), .syscall_i(sys), .break_i(brk), .eret_i(eret), .load_i(load),
    .store_i(store), .mem_size_i(size), .mem_addr_i(addr), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .excepttype_o(b_exc),
    .current_inst_addr_o(b_cur), .is_in_delayslot_o(b_ds), .bad_addr_o(b_bad),
    .mem_cancel_o(b_cancel), .flush_o(b_flush), .new_pc_o(b_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; valid = 0; ds = 0; adel = 0; ri = 0; ov = 0; trap = 0;
    sys = 0; brk = 0; eret = 0; load = 0; store = 0; size = 2'd0;
    addr = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 0; int_i = 6'h3f; status = 32'h0000ff01; cause = '0; epc = '0;
    clear_in();
    valid = 1; pc = 32'h8000_0100;
    step(); step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL rst_exc got=%h want=0", a_exc); end
    total++; if (a_flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", a_flush); end
    total++; if ({a_cur, a_bad, a_npc, a_ds} !== '0) begin bad++;
      $display("FAIL rst_regs cur=%h bad=%h npc=%h ds=%b want all 0", a_cur, a_bad, a_npc, a_ds); end
    rst = 1;
    step(); step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL int_early got=%h want=0", a_exc); end
    step();
    total++; if (a_exc !== 32'h1) begin bad++; $display("FAIL int_exc got=%h want=1", a_exc); end
    total++; if (a_flush !== 1'b1 || a_npc !== 32'hBFC00380) begin bad++;
      $display("FAIL int_flush flush=%b npc=%h want 1/bfc00380", a_flush, a_npc); end
    total++; if (a_cur !== 32'h8000_0100) begin bad++; $display("FAIL int_pc got=%h want=80000100", a_cur); end
    int_i = 6'h0;
    valid = 0;
    step();
    total++; if (a_exc !== 32'h0 || a_flush !== 1'b0) begin bad++;
      $display("FAIL int_pulse exc=%h flush=%b want 0/0", a_exc, a_flush); end
    idle(4);
  endtask

  task automatic test_priority();
    clear_in();
    valid = 1; pc = 32'h8000_1000; ds = 1; ri = 1; ov = 1; sys = 1;
    #1;
    total++; if (a_cancel !== 1'b1) begin bad++; $display("FAIL prio_cancel got=%b want=1", a_cancel); end
    step();
    total++; if (a_exc !== 32'ha) begin bad++; $display("FAIL prio_exc got=%h want=a", a_exc); end
    total++; if (a_cur !== 32'h8000_1000 || a_ds !== 1'b1) begin bad++;
      $display("FAIL prio_pc cur=%h ds=%b want 80001000/1", a_cur, a_ds); end
    total++; if (a_bad !== 32'h0) begin bad++; $display("FAIL prio_badhold got=%h want=0", a_bad); end
    idle(1);
    total++; if (a_flush !== 1'b0) begin bad++; $display("FAIL prio_flush_end got=%b want=0", a_flush); end
    idle(1);
  endtask

  task automatic test_misalign();
    clear_in();
    valid = 1; pc = 32'h8000_1100; load = 1; size = 2'd2; addr = 32'h8000_2002;
    #1;
    total++; if (a_cancel !== 1'b1) begin bad++; $display("FAIL adel_cancel got=%b want=1", a_cancel); end
    step();
    total++; if (a_exc !== 32'h4 || a_bad !== 32'h8000_2002) begin bad++;
      $display("FAIL adel exc=%h bad=%h want 4/80002002", a_exc, a_bad); end
    idle(1);
    valid = 1; store = 1; size = 2'd1; addr = 32'h8000_2001;
    #1;
    total++; if (a_cancel !== 1'b1) begin bad++; $display("FAIL ades_cancel got=%b want=1", a_cancel); end
    step();
    total++; if (a_exc !== 32'h5 || a_bad !== 32'h8000_2001) begin bad++;
      $display("FAIL ades exc=%h bad=%h want 5/80002001", a_exc, a_bad); end
    idle(1);
    valid = 1; store = 1; size = 2'd2; addr = 32'h8000_2004;
    #1;
    total++; if (a_cancel !== 1'b0) begin bad++; $display("FAIL aligned_cancel got=%b want=0", a_cancel); end
    step();
    total++; if (a_exc !== 32'h0 || a_bad !== 32'h8000_2001) begin bad++;
      $display("FAIL aligned exc=%h bad=%h want 0/80002001", a_exc, a_bad); end
    clear_in();
    valid = 1; load = 1; size = 2'd0; addr = 32'h8000_2003;
    step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL byte_odd got=%h want=0", a_exc); end
    idle(1);
  endtask

  task automatic test_eret();
    clear_in();
    valid = 1; pc = 32'h8000_1200; eret = 1; epc = 32'hBFC0_0100;
    step();
    total++; if (a_exc !== 32'he || a_npc !== 32'hBFC0_0100) begin bad++;
      $display("FAIL eret exc=%h npc=%h want e/bfc00100", a_exc, a_npc); end
    idle(2);
  endtask

  task automatic test_flush3();
    idle(4);
    valid = 1; pc = 32'h8000_3000; sys = 1;
    step();
    total++; if (b_exc !== 32'h8 || b_flush !== 1'b1) begin bad++;
      $display("FAIL f3_first exc=%h flush=%b want 8/1", b_exc, b_flush); end
    pc = 32'h8000_3004;
    #1;
    total++; if (b_cancel !== 1'b1) begin bad++; $display("FAIL f3_cancel got=%b want=1", b_cancel); end
    step();
    total++; if (b_exc !== 32'h0 || b_flush !== 1'b1) begin bad++;
      $display("FAIL f3_second exc=%h flush=%b want 0/1", b_exc, b_flush); end
    clear_in();
    step();
    total++; if (b_flush !== 1'b1) begin bad++; $display("FAIL f3_third got=%b want=1", b_flush); end
    step();
    total++; if (b_flush !== 1'b0) begin bad++; $display("FAIL f3_end got=%b want=0", b_flush); end
    idle(1);
  endtask

  task automatic test_stall();
    idle(4);
    stall = 1; valid = 1; pc = 32'h8000_4000; ov = 1;
    #1;
    total++; if (a_cancel !== 1'b0) begin bad++; $display("FAIL stall_cancel got=%b want=0", a_cancel); end
    step(); step();
    total++; if (a_exc !== 32'h0 || a_flush !== 1'b0) begin bad++;
      $display("FAIL stall_hold exc=%h flush=%b want 0/0", a_exc, a_flush); end
    stall = 0;
    #1;
    total++; if (a_cancel !== 1'b1) begin bad++; $display("FAIL unstall_cancel got=%b want=1", a_cancel); end
    step();
    total++; if (a_exc !== 32'hc) begin bad++; $display("FAIL unstall_exc got=%h want=c", a_exc); end
    idle(4);
    // Software interrupt via Cause[8]: deferred under stall, ignored for bubbles and with EXL set.
    cause = 32'h0000_0100;
    stall = 1; valid = 1; pc = 32'h8000_4100;
    step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL int_stall got=%h want=0", a_exc); end
    stall = 0;
    step();
    total++; if (a_exc !== 32'h1 || a_cur !== 32'h8000_4100) begin bad++;
      $display("FAIL int_unstall exc=%h cur=%h want 1/80004100", a_exc, a_cur); end
    idle(2);
    #1;
    total++; if (a_cancel !== 1'b0) begin bad++; $display("FAIL bubble_cancel got=%b want=0", a_cancel); end
    step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL bubble_int got=%h want=0", a_exc); end
    status = 32'h0000_ff03; valid = 1;
    step();
    total++; if (a_exc !== 32'h0) begin bad++; $display("FAIL exl_int got=%h want=0", a_exc); end
    status = 32'h0000_ff01; cause = '0;
    idle(4);
  endtask

  task automatic test_reset_midflush();
    idle(4);
    valid = 1; pc = 32'h8000_5000; sys = 1;
    step();
    total++; if (b_flush !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b want=1", b_flush); end
    clear_in();
    rst = 0;
    #1;
    total++; if (b_flush !== 1'b0 || a_flush !== 1'b0 || b_exc !== 32'h0) begin bad++;
      $display("FAIL mid_rst bflush=%b aflush=%b bexc=%h want 0/0/0", b_flush, a_flush, b_exc); end
    step();
    rst = 1;
    idle(2);
    total++; if (b_flush !== 1'b0) begin bad++; $display("FAIL mid_after got=%b want=0", b_flush); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_misalign();
    test_eret();
    test_flush3();
    test_stall();
    test_reset_midflush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
